// File: rtl/tick_gen_bank.sv
// Bank of independent runtime-programmable clock dividers, each emitting single-cycle ticks
// periodically or as a one-shot. Define TICK_GEN_SYNC_EN to add the SYNC phase-realign input.
module tick_gen_bank #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEFAULT_DIV = 1000,
    localparam int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CHANNELS-1:0] EN,
    input  logic                LOAD,
    input  logic [CH_W-1:0]     LOAD_CH,
    input  logic [CNT_W-1:0]    LOAD_DIV,
    input  logic                LOAD_MODE,
    input  logic [CHANNELS-1:0] START,
`ifdef TICK_GEN_SYNC_EN
    input  logic                SYNC,
`endif
    output logic [CHANNELS-1:0] PULSE,
    output logic [CHANNELS-1:0] BUSY
);

    logic [CNT_W-1:0]    div_q [CHANNELS];
    logic [CNT_W-1:0]    div_d [CHANNELS];
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];
    logic [CHANNELS-1:0] mode_q, mode_d;
    logic [CHANNELS-1:0] armed_q, armed_d;
    logic [CHANNELS-1:0] pulse_q, pulse_d;
    logic [CHANNELS-1:0] busy_q;

    // Per-channel next state; priority is LOAD > SYNC > START > count.
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            div_d[i]   = div_q[i];
            cnt_d[i]   = cnt_q[i];
            mode_d[i]  = mode_q[i];
            armed_d[i] = armed_q[i];
            pulse_d[i] = 1'b0;

            if (LOAD && (LOAD_CH == CH_W'(i))) begin
                div_d[i]   = LOAD_DIV;
                mode_d[i]  = LOAD_MODE;
                cnt_d[i]   = '0;
                armed_d[i] = 1'b0;
            end
`ifdef TICK_GEN_SYNC_EN
            else if (SYNC) begin
                cnt_d[i] = '0;
            end
`endif
            else if (mode_q[i] && START[i]) begin
                armed_d[i] = 1'b1;
                cnt_d[i]   = '0;
            end
            else if (EN[i] && (!mode_q[i] || armed_q[i])) begin
                // Compare match ends the period; a one-shot disarms on the same edge.
                if (cnt_q[i] == div_q[i]) begin
                    cnt_d[i]   = '0;
                    pulse_d[i] = 1'b1;
                    armed_d[i] = 1'b0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                div_q[i] <= CNT_W'(DEFAULT_DIV);
                cnt_q[i] <= '0;
            end
            mode_q  <= '0;
            armed_q <= '0;
            pulse_q <= '0;
            busy_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            mode_q  <= mode_d;
            armed_q <= armed_d;
            pulse_q <= pulse_d;
            busy_q  <= armed_d;
        end
    end

    assign PULSE = pulse_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_tick_gen_bank.sv
// Self-checking bench for tick_gen_bank: directed latency checks plus random traffic
// compared each cycle against a countdown-based reference model.
module tb_tick_gen_bank;

    localparam int CH  = 5;
    localparam int CW  = 3;
    localparam int NW  = 16;
    localparam int DEF = 1000;

    logic          CLK, RST;
    logic [CH-1:0] en, start;
    logic          load, load_mode, sync;
    logic [CW-1:0] load_ch;
    logic [NW-1:0] load_div;
    logic [CH-1:0] PULSE, BUSY;

    tick_gen_bank #(.CHANNELS(CH), .CNT_W(NW), .DEFAULT_DIV(DEF)) dut (
        .CLK(CLK), .RST(RST), .EN(en), .LOAD(load), .LOAD_CH(load_ch),
        .LOAD_DIV(load_div), .LOAD_MODE(load_mode), .START(start),
`ifdef TICK_GEN_SYNC_EN
        .SYNC(sync),
`endif
        .PULSE(PULSE), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Reference model: per channel, enabled edges left until the next tick.
    int            m_div   [CH];
    bit            m_mode  [CH];
    int            m_left  [CH];
    bit            m_armed [CH];
    logic [CH-1:0] exp_pulse, exp_busy;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_div[i]   = DEF;
            m_mode[i]  = 1'b0;
            m_left[i]  = DEF + 1;
            m_armed[i] = 1'b0;
        end
        exp_pulse = '0;
        exp_busy  = '0;
    endtask

    task automatic model_step();
        for (int i = 0; i < CH; i++) begin
            exp_pulse[i] = 1'b0;
            if (load && int'(load_ch) == i) begin
                m_div[i]   = int'(load_div);
                m_mode[i]  = load_mode;
                m_left[i]  = m_div[i] + 1;
                m_armed[i] = 1'b0;
            end else if (sync) begin
                m_left[i] = m_div[i] + 1;
            end else if (m_mode[i] && start[i]) begin
                m_armed[i] = 1'b1;
                m_left[i]  = m_div[i] + 1;
            end else if (en[i] && (!m_mode[i] || m_armed[i])) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    exp_pulse[i] = 1'b1;
                    m_left[i]    = m_div[i] + 1;
                    m_armed[i]   = 1'b0;
                end
            end
            exp_busy[i] = m_armed[i];
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge CLK);
        @(negedge CLK);
        chk("pulse_vec", PULSE, exp_pulse);
        chk("busy_vec", BUSY, exp_busy);
    endtask

    task automatic do_load(input int ch, input int div, input bit mode);
        load = 1'b1; load_ch = CW'(ch); load_div = NW'(div); load_mode = mode;
        cycle();
        load = 1'b0;
    endtask

    // Returns number of edges until PULSE[ch] is seen high, or -1 within max edges.
    task automatic run_until(input int ch, input int max, output int at);
        at = -1;
        for (int n = 1; n <= max; n++) begin
            cycle();
            if (PULSE[ch]) begin
                at = n;
                break;
            end
        end
    endtask

    int at, at0, at1, hi;

    initial begin
        RST = 1'b1; en = '0; start = '0; load = 1'b0; load_ch = '0;
        load_div = '0; load_mode = 1'b0; sync = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_pulse", PULSE, 0);
        chk("reset_busy", BUSY, 0);
        RST = 1'b0;

        // Defaults after reset: DIV=1000 periodic
        en = '1;
        run_until(0, 1100, at);
        chk("default_first_tick", at, 1001);
        run_until(0, 1100, at);
        chk("default_period", at, 1001);

        // DIV=4 periodic and DIV=0 continuous
        do_load(1, 4, 1'b0);
        run_until(1, 10, at);
        chk("div4_first", at, 5);
        run_until(1, 10, at);
        chk("div4_period", at, 5);
        do_load(2, 0, 1'b0);
        hi = 0;
        for (int n = 0; n < 10; n++) begin
            cycle();
            hi += int'(PULSE[2]);
        end
        chk("div0_continuous", hi, 10);

        // One-shot DIV=9, then a restart 5 edges after START
        do_load(0, 9, 1'b1);
        start[0] = 1'b1; cycle(); start[0] = 1'b0;
        chk("oneshot_busy_rise", BUSY[0], 1);
        run_until(0, 20, at);
        chk("oneshot_latency", at, 10);
        chk("oneshot_busy_fall", BUSY[0], 0);
        start[0] = 1'b1; cycle(); start[0] = 1'b0;
        repeat (4) cycle();
        start[0] = 1'b1; cycle(); start[0] = 1'b0;
        run_until(0, 20, at);
        chk("oneshot_restart_latency", at, 10);

        // EN gating: DIV=3, EN low for 2 cycles mid-count
        do_load(3, 3, 1'b0);
        cycle();
        en[3] = 1'b0;
        repeat (2) cycle();
        en[3] = 1'b1;
        run_until(3, 10, at);
        chk("en_gated_latency", 3 + at, 6);

        // LOAD into a counting channel, then an out-of-range LOAD
        repeat (2) cycle();
        do_load(1, 4, 1'b0);
        chk("load_kills_pulse", PULSE[1], 0);
        run_until(1, 10, at);
        chk("reload_latency", at, 5);
        do_load(CH, 0, 1'b1);
        run_until(1, 10, at);
        chk("bad_ch_no_effect", at, 4);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            en    = CH'($urandom);
            start = '0;
            for (int i = 0; i < CH; i++) start[i] = ($urandom_range(0, 5) == 0);
            load      = ($urandom_range(0, 7) == 0);
            load_ch   = CW'($urandom_range(0, 7));
            load_div  = NW'($urandom_range(0, 6));
            load_mode = 1'($urandom);
`ifdef TICK_GEN_SYNC_EN
            sync = ($urandom_range(0, 15) == 0);
`endif
            cycle();
        end
        en = '1; start = '0; load = 1'b0; sync = 1'b0;

`ifdef TICK_GEN_SYNC_EN
        // SYNC realigns two DIV=7 channels with offset phases
        do_load(0, 7, 1'b0);
        repeat (3) cycle();
        do_load(1, 7, 1'b0);
        repeat (2) cycle();
        sync = 1'b1; cycle(); sync = 1'b0;
        at0 = -1; at1 = -1;
        for (int n = 1; n <= 12; n++) begin
            cycle();
            if (PULSE[0] && at0 < 0) at0 = n;
            if (PULSE[1] && at1 < 0) at1 = n;
        end
        chk("sync_ch0", at0, 8);
        chk("sync_ch1", at1, 8);
`endif

        // Async reset mid-count with outputs active
        do_load(2, 0, 1'b0);
        do_load(4, 50, 1'b1);
        start[4] = 1'b1; cycle(); start[4] = 1'b0;
        repeat (3) cycle();
        chk("pre_reset_pulse2", PULSE[2], 1);
        chk("pre_reset_busy4", BUSY[4], 1);
        #2;
        RST = 1'b1;
        #1;
        chk("async_reset_pulse", PULSE, 0);
        chk("async_reset_busy", BUSY, 0);
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        run_until(0, 1100, at);
        chk("post_reset_div_default", at, 1001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_gen_bank.md
# tick_gen_bank

Parametrised bank of independent tick generators. It is the multi-channel successor to the fixed 1 kHz pulse generator. Each channel divides the system clock by a runtime-loadable divisor and emits single-cycle strobes, either periodically or as a one-shot after a START trigger. It sits beside the SRAM/counter demo logic and supplies the timebases that logic consumes (refresh, sample, debounce ticks).

## Interface
- CHANNELS, 4, number of independent channels (1..16)
- CNT_W, 16, divisor/counter width in bits (>=2)
- DEFAULT_DIV, 1000, divisor value loaded into every channel at reset (must fit CNT_W)
- CH_W, derived: max(1, clog2(CHANNELS)), channel index width (localparam)

- CLK  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- EN  in  CHANNELS  per-channel count enable
- LOAD  in  1  write strobe for divisor/mode of channel LOAD_CH
- LOAD_CH  in  CH_W  channel index for LOAD
- LOAD_DIV  in  CNT_W  new divisor
- LOAD_MODE  in  1  0 = periodic, 1 = one-shot
- START  in  CHANNELS  per-channel one-shot trigger (ignored in periodic mode)
- SYNC  in  1  only when TICK_GEN_SYNC_EN is defined: realigns all channels
- PULSE  out  CHANNELS  registered single-cycle tick per channel
- BUSY  out  CHANNELS  one-shot armed/counting flag per channel

## Operation
- Per-channel state: DIV[CNT_W], MODE, CNT[CNT_W], ARMED. PULSE and BUSY are registered.
- Reset (async, immediate): DIV = DEFAULT_DIV, MODE = periodic, CNT = 0, ARMED = 0, PULSE = 0, BUSY = 0.
- Periodic mode, EN=1: if CNT == DIV then CNT <= 0 and PULSE <= 1; else CNT <= CNT+1 and PULSE <= 0. Period = DIV+1 cycles.
- Periodic mode, EN=0: CNT holds and PULSE <= 0.
- One-shot mode: START[i] sets ARMED <= 1 and CNT <= 0.
  - While ARMED and EN, counting follows the periodic rule.
  - On the compare match, PULSE <= 1 and ARMED <= 0 on the same edge.
  - When not ARMED, CNT holds at 0 and PULSE = 0. BUSY mirrors ARMED.
- START while already armed restarts the count from 0 with no pulse. START with EN=0 still arms, but counting waits for EN.
- LOAD writes DIV and MODE of channel LOAD_CH, clears its CNT and ARMED, and forces its PULSE <= 0 that cycle. LOAD_CH >= CHANNELS: the write is ignored.
- Per-channel priority: RST > LOAD > SYNC > START > count.
- DIV = 0: periodic mode gives PULSE high every enabled cycle. One-shot mode gives a pulse on the edge after the START edge.
- CNT never exceeds DIV. If DIV is lowered by LOAD, CNT has already been cleared, so no wrap past the compare is possible.

## Timing
- Latency, periodic: with EN first high at edge 1 and CNT=0, PULSE rises after edge DIV+1. It then repeats every DIV+1 edges.
- Latency, one-shot: START sampled at edge k gives PULSE high for exactly one cycle after edge k+DIV+1, assuming EN stays high.
- Each enabled cycle with EN low adds one cycle of delay.
- BUSY rises after edge k and falls on the same edge that raises PULSE.
- LOAD takes effect on the next edge. Counting restarts from 0 on the following enabled edge.
- There are no combinational paths from inputs to outputs.

## Configuration
- TICK_GEN_SYNC_EN defined: the SYNC port exists.
  - SYNC=1 clears CNT of every channel and forces PULSE <= 0 on all channels.
  - ARMED is preserved, so armed one-shots restart their count.
  - Channels realign phase and their next ticks coincide if their DIVs are equal.
- TICK_GEN_SYNC_EN undefined: the SYNC port and all its logic are absent, and behaviour is otherwise identical.

## Test plan
- Reset defaults: RST pulse, then EN=all ones, no LOAD -> each PULSE first high after edge 1001, then every 1001 cycles. BUSY stays 0.
- Load and DIV=0: LOAD ch1 DIV=4 periodic, EN[1]=1 -> PULSE[1] high one cycle in every 5. LOAD ch2 DIV=0 -> PULSE[2] high continuously while EN[2]=1.
- One-shot: LOAD ch0 DIV=9 one-shot, START[0] at edge k -> BUSY[0] high after k, PULSE[0] high only after edge k+10, BUSY[0] low at that edge. A second START at k+5 moves the pulse to k+15.
- EN gating: periodic DIV=3, drop EN for 2 cycles mid-count -> PULSE delayed by exactly 2 cycles, and no pulse while EN=0.
- Mid-operation events: LOAD to the counting channel, LOAD_CH=CHANNELS, async RST mid-count -> respectively counter cleared with no pulse; no state change; all outputs 0 immediately with DIV back to 1000.
- With TICK_GEN_SYNC_EN: ch0 and ch1 at DIV=7 with offset phases, SYNC for 1 cycle -> both PULSE coincide 8 cycles later. Build without the macro and confirm the periodic checks above still pass.
